// File: rtl/ex_muldiv_unit.sv
// ex_muldiv_unit: RV32M iterative multiply/divide execute unit.
// Takes operands, func3 and rd from ID/EX, holds the pipeline via stall_out
// while running, and presents result_out/RD_out with a one-cycle done_out.
// Ports: clk, reset (async active-low), start_in, flush_in, func3_in,
//        Rd1_in, Rd2_in, RD_in -> stall_out, done_out, result_out, RD_out.
// Option: MULDIV_FAST_MUL_EN selects a single-cycle multiplier (IDLE->DONE).
module ex_muldiv_unit #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned CNT_W = 6
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start_in,
  input  logic            flush_in,
  input  logic [2:0]      func3_in,
  input  logic [XLEN-1:0] Rd1_in,
  input  logic [XLEN-1:0] Rd2_in,
  input  logic [4:0]      RD_in,
  output logic            stall_out,
  output logic            done_out,
  output logic [XLEN-1:0] result_out,
  output logic [4:0]      RD_out
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CALC  = 2'd1,
    FIXUP = 2'd2,
    DONE  = 2'd3
  } state_e;

  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [XLEN-1:0]   hi_q, hi_d;        // product high half / partial remainder
  logic [XLEN-1:0]   lo_q, lo_d;        // multiplier bits / dividend-quotient
  logic [XLEN-1:0]   op_q, op_d;        // multiplicand / divisor magnitude
  logic [2:0]        func3_q, func3_d;
  logic              neg_q, neg_d;      // product or quotient needs negation
  logic              rem_neg_q, rem_neg_d;
  logic [4:0]        rd_q, rd_d;
  logic [XLEN-1:0]   result_q, result_d;
  logic [4:0]        rd_out_q, rd_out_d;

  // Launch-time decode
  logic            is_div;
  logic            sgn_a, sgn_b;
  logic            neg_a, neg_b;
  logic [XLEN-1:0] mag_a, mag_b;
  logic            div_zero, div_ovf;
  logic [XLEN-1:0] special_res;

  assign is_div   = func3_in[2];
  assign sgn_a    = (func3_in == 3'b001) || (func3_in == 3'b010) ||
                    (func3_in == 3'b100) || (func3_in == 3'b110);
  assign sgn_b    = (func3_in == 3'b001) || (func3_in == 3'b100) ||
                    (func3_in == 3'b110);
  assign neg_a    = sgn_a & Rd1_in[XLEN-1];
  assign neg_b    = sgn_b & Rd2_in[XLEN-1];
  assign mag_a    = neg_a ? -Rd1_in : Rd1_in;
  assign mag_b    = neg_b ? -Rd2_in : Rd2_in;
  assign div_zero = is_div && (Rd2_in == '0);
  assign div_ovf  = is_div && !func3_in[0] && (Rd1_in == MIN_NEG) && (Rd2_in == '1);

  always_comb begin
    special_res = '0;
    if (div_zero) begin
      special_res = func3_in[1] ? Rd1_in : '1;
    end else begin
      special_res = func3_in[1] ? '0 : MIN_NEG;
    end
  end

  // One iteration of shift-add (multiply) and restoring shift-subtract (divide)
  logic [XLEN:0] mul_sum;
  logic [XLEN:0] div_trial;
  logic [XLEN:0] div_diff;

  assign mul_sum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, op_q} : '0);
  assign div_trial = {hi_q, lo_q[XLEN-1]};
  assign div_diff  = div_trial - {1'b0, op_q};

  // Sign fix-up of the magnitude results
  logic [2*XLEN-1:0] prod_fix;
  logic [XLEN-1:0]   quo_fix, rem_fix;
  logic [XLEN-1:0]   fix_res;

  assign prod_fix = neg_q ? -{hi_q, lo_q} : {hi_q, lo_q};
  assign quo_fix  = neg_q ? -lo_q : lo_q;
  assign rem_fix  = rem_neg_q ? -hi_q : hi_q;

  always_comb begin
    fix_res = '0;
    if (func3_q[2]) begin
      fix_res = func3_q[1] ? rem_fix : quo_fix;
    end else if (func3_q == 3'b000) begin
      fix_res = prod_fix[XLEN-1:0];
    end else begin
      fix_res = prod_fix[2*XLEN-1:XLEN];
    end
  end

`ifdef MULDIV_FAST_MUL_EN
  logic [2*XLEN-1:0] fast_a, fast_b, fast_prod;
  logic [XLEN-1:0]   fast_res;

  // Sign-extend to full width; the low 2*XLEN bits of the product are then
  // correct for every signed/unsigned combination.
  assign fast_a    = {{XLEN{neg_a}}, Rd1_in};
  assign fast_b    = {{XLEN{neg_b}}, Rd2_in};
  assign fast_prod = fast_a * fast_b;
  assign fast_res  = (func3_in == 3'b000) ? fast_prod[XLEN-1:0]
                                          : fast_prod[2*XLEN-1:XLEN];
`endif

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    op_d      = op_q;
    func3_d   = func3_q;
    neg_d     = neg_q;
    rem_neg_d = rem_neg_q;
    rd_d      = rd_q;
    result_d  = result_q;
    rd_out_d  = rd_out_q;

    case (state_q)
      IDLE: begin
        if (start_in && !flush_in) begin
          func3_d   = func3_in;
          rd_d      = RD_in;
          neg_d     = neg_a ^ neg_b;
          rem_neg_d = neg_a;
          hi_d      = '0;
          lo_d      = mag_a;
          op_d      = mag_b;
          cnt_d     = CNT_W'(XLEN - 1);
          if (div_zero || div_ovf) begin
            result_d = special_res;
            rd_out_d = RD_in;
            state_d  = DONE;
          end
`ifdef MULDIV_FAST_MUL_EN
          else if (!is_div) begin
            result_d = fast_res;
            rd_out_d = RD_in;
            state_d  = DONE;
          end
`endif
          else begin
            state_d = CALC;
          end
        end
      end
      CALC: begin
        if (func3_q[2]) begin
          if (!div_diff[XLEN]) begin
            hi_d = div_diff[XLEN-1:0];
            lo_d = {lo_q[XLEN-2:0], 1'b1};
          end else begin
            hi_d = div_trial[XLEN-1:0];
            lo_d = {lo_q[XLEN-2:0], 1'b0};
          end
        end else begin
          hi_d = mul_sum[XLEN:1];
          lo_d = {mul_sum[0], lo_q[XLEN-1:1]};
        end
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == '0) begin
          state_d = FIXUP;
        end
      end
      FIXUP: begin
        result_d = fix_res;
        rd_out_d = rd_q;
        state_d  = DONE;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Flush overrides any transition, including a result load this cycle.
    if (flush_in) begin
      state_d  = IDLE;
      result_d = result_q;
      rd_out_d = rd_out_q;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      op_q      <= '0;
      func3_q   <= '0;
      neg_q     <= 1'b0;
      rem_neg_q <= 1'b0;
      rd_q      <= '0;
      result_q  <= '0;
      rd_out_q  <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      op_q      <= op_d;
      func3_q   <= func3_d;
      neg_q     <= neg_d;
      rem_neg_q <= rem_neg_d;
      rd_q      <= rd_d;
      result_q  <= result_d;
      rd_out_q  <= rd_out_d;
    end
  end

  assign stall_out  = ((state_q == IDLE) && start_in && !flush_in) ||
                      (state_q == CALC) || (state_q == FIXUP);
  assign done_out   = (state_q == DONE);
  assign result_out = result_q;
  assign RD_out     = rd_out_q;

endmodule

// File: doc/ex_muldiv_unit.md
Name: ex_muldiv_unit

Overview:
- RV32M multiply/divide execute unit, sitting directly downstream of the ID/EX pipeline register.
- Consumes the operand pair, func3 and destination register from the ID/EX register and runs one iterative multiply or divide.
- Holds the pipeline through a stall output while it runs.
- Presents a 32-bit result and destination tag to the EX/MEM side with a one-cycle done pulse.

Parameters:
- XLEN, 32, operand/result width; only 32 is supported.
- CNT_W, 6, iteration counter width; must hold XLEN.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-low reset.
- start_in  input  1  launch request: M-extension instruction present in EX.
- flush_in  input  1  abort the current or pending operation.
- func3_in  input  3  operation: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- Rd1_in  input  32  rs1 operand.
- Rd2_in  input  32  rs2 operand.
- RD_in  input  5  destination register index.
- stall_out  output  1  freeze upstream stages (ID/EX enable low).
- done_out  output  1  one-cycle pulse; result and RD valid.
- result_out  output  32  operation result; held until the next launch.
- RD_out  output  5  captured destination index; held with the result.

Behaviour:
- Reset (reset==0, asynchronous): state=IDLE; result_out=0; RD_out=0; done_out=0; counter, accumulators and sign flags cleared. Reset mid-operation abandons the operation and produces no done.
- States: IDLE, CALC, FIXUP, DONE.
- IDLE, start_in=1 and flush_in=0:
  - capture func3, RD, the operand magnitudes and the sign flags.
  - Signedness: MULH/DIV/REM treat both operands as signed; MULHSU treats rs1 signed and rs2 unsigned; the rest are unsigned.
  - Load counter=XLEN-1.
  - Go to CALC, or straight to DONE for a special case.
- Special cases, detected in IDLE; the result is loaded directly and the unit goes to DONE:
  - Divide by zero (Rd2=0): DIV/DIVU give 0xFFFFFFFF; REM/REMU give Rd1.
  - Signed overflow (DIV/REM with Rd1=0x80000000 and Rd2=0xFFFFFFFF): DIV gives 0x80000000; REM gives 0.
- CALC, one bit per cycle, counter decrements each cycle; when counter==0 go to FIXUP.
  - Multiply: shift-add into a 64-bit accumulator.
  - Divide: restoring shift-subtract.
- FIXUP, one cycle:
  - Negate as required: product when the signs differ; quotient when signs differ; remainder takes the dividend's sign.
  - Select the result: low 32 bits for MUL, high 32 bits for the MULH variants, quotient or remainder for divide.
  - Go to DONE.
- DONE: done_out=1 for exactly this cycle; result_out and RD_out valid; go to IDLE.
- Latency from the start edge:
  - Iterative operation: done_out is high in the 34th cycle.
  - Special case: done_out is high in the 1st cycle.
- stall_out (combinational):
  - high in IDLE while start_in=1 and flush_in=0;
  - high throughout CALC and FIXUP;
  - low in DONE, so the pipeline advances on the done cycle.
- start_in outside IDLE is ignored; no queueing.
- flush_in=1 in any state:
  - next state is IDLE, no done pulse;
  - result_out and RD_out keep their previous values;
  - flush wins over a simultaneous start.
- start_in in the DONE cycle is not accepted; it is sampled again once back in IDLE.
- Back-to-back operations therefore have a minimum one-cycle IDLE gap.

Optional Feature:
- Macro: MULDIV_FAST_MUL_EN.
- Defined:
  - MUL/MULH/MULHSU/MULHU use a single-cycle 64-bit signed/unsigned product, with the sign extension chosen by func3.
  - Launch goes IDLE->DONE; done_out is high 1 cycle after start.
  - Divide path unchanged.
- Undefined:
  - Multiply uses the iterative CALC/FIXUP path; 34-cycle latency.

Test Plan:
- DIVU, Rd1=100, Rd2=7, RD=5 -> stall_out high for 33 cycles; done at cycle 34 with result 14 and RD_out 5; REMU on the same operands gives 2.
- DIV, Rd1=0xFFFFFF9C (-100), Rd2=7 -> result 0xFFFFFFF2 (-14); REM on the same operands gives 0xFFFFFFFE (-2).
- Special cases -> done at cycle 1, no CALC:
  - DIV 0x80000000 / 0xFFFFFFFF gives 0x80000000;
  - REM on the same operands gives 0;
  - DIVU by 0 gives 0xFFFFFFFF;
  - REMU 0x1234 by 0 gives 0x1234.
- MULH, Rd1=0xFFFFFFFF, Rd2=0xFFFFFFFF -> result 0; MULHU gives 0xFFFFFFFE; MULHSU gives 0xFFFFFFFF; MUL gives 1.
  - Latency is 34 cycles, or 1 cycle with MULDIV_FAST_MUL_EN.
- Interruptions:
  - flush_in pulse at cycle 10 of a DIVU -> IDLE next cycle, no done, result_out unchanged.
  - reset pulled low at cycle 20 -> all outputs 0 immediately.
- start_in held high continuously with two queued operations -> second launch accepted only after the DONE cycle plus one IDLE cycle; start_in during CALC is ignored.
